// File: rtl/comp_stream_stats.sv
// rtl/comp_stream_stats.sv - registered a/b comparator with saturating outcome counters and running min/max of a
module comp_stream_stats #(
    parameter int n     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [n-1:0]     a,
    input  logic [n-1:0]     b,
    input  logic             signed_mode,
    input  logic             clear,
    output logic             out_valid,
    output logic             sma,
    output logic             eq,
    output logic             gre,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [n-1:0]     a_min,
    output logic [n-1:0]     a_max,
    output logic             stats_valid
);

    typedef enum logic {EMPTY = 1'b0, TRACK = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [n-1:0]     min_d, max_d;
    logic [CNT_W-1:0] lt_d, eq_d, gt_d;
    logic             a_lt_b, a_gt_b, a_eq_b;
    logic             a_lt_min, a_gt_max;

    // x < y under the ordering selected by the sample's own mode bit
    function automatic logic less(input logic [n-1:0] x, input logic [n-1:0] y, input logic s);
        if (s) begin
            less = ($signed(x) < $signed(y));
        end else begin
            less = (x < y);
        end
    endfunction

    // count up by one, holding at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == {CNT_W{1'b1}}) begin
            sat_inc = c;
        end else begin
            sat_inc = c + CNT_W'(1);
        end
    endfunction

    assign a_lt_b   = less(a, b, signed_mode);
    assign a_gt_b   = less(b, a, signed_mode);
    assign a_eq_b   = (a == b);
    assign a_lt_min = less(a, a_min, signed_mode);
    assign a_gt_max = less(a_max, a, signed_mode);

    // next statistics: clear restarts from zero first, then an accepted sample is folded in
    always_comb begin
        state_d = state_q;
        min_d   = a_min;
        max_d   = a_max;
        lt_d    = lt_cnt;
        eq_d    = eq_cnt;
        gt_d    = gt_cnt;
        if (clear) begin
            state_d = EMPTY;
            min_d   = '0;
            max_d   = '0;
            lt_d    = '0;
            eq_d    = '0;
            gt_d    = '0;
        end
        if (in_valid) begin
            if (a_lt_b) begin
                lt_d = sat_inc(lt_d);
            end else if (a_gt_b) begin
                gt_d = sat_inc(gt_d);
            end else begin
                eq_d = sat_inc(eq_d);
            end
            if (clear || state_q == EMPTY) begin
                state_d = TRACK;
                min_d   = a;
                max_d   = a;
            end else begin
                if (a_lt_min) begin
                    min_d = a;
                end
                if (a_gt_max) begin
                    max_d = a;
                end
            end
        end
    end

    // state, statistics and result flags; flags only move when a sample is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            a_min     <= '0;
            a_max     <= '0;
            lt_cnt    <= '0;
            eq_cnt    <= '0;
            gt_cnt    <= '0;
            out_valid <= 1'b0;
            sma       <= 1'b0;
            eq        <= 1'b0;
            gre       <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_min     <= min_d;
            a_max     <= max_d;
            lt_cnt    <= lt_d;
            eq_cnt    <= eq_d;
            gt_cnt    <= gt_d;
            out_valid <= in_valid;
            if (in_valid) begin
                sma <= a_lt_b;
                eq  <= a_eq_b;
                gre <= a_gt_b;
            end
        end
    end

    assign stats_valid = (state_q == TRACK);

endmodule

// File: doc/comp_stream_stats.md
COMP_STREAM_STATS -- requirements
Module: comp_stream_stats

Interface
REQ-001 Parameter n, default 8, operand width in bits (n >= 2).
REQ-002 Parameter CNT_W, default 16, width of each outcome counter (CNT_W >= 2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  a/b/signed_mode carry a sample this cycle.
REQ-006 a, b  input  n each  operands.
REQ-007 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned.
REQ-008 clear  input  1  synchronous statistics restart.
REQ-009 out_valid  output  1  sma/eq/gre hold a fresh result.
REQ-010 sma, eq, gre  output  1 each  registered a<b, a==b, a>b.
REQ-011 lt_cnt, eq_cnt, gt_cnt  output  CNT_W each  saturating outcome counters.
REQ-012 a_min, a_max  output  n each  running minimum and maximum of a.
REQ-013 stats_valid  output  1  a_min/a_max hold at least one sample.

Function
REQ-014 Latency one cycle: sample accepted at edge k -> out_valid=1 and flags valid from edge k until edge k+1.
REQ-015 in_valid=0 at an edge -> out_valid=0 next cycle; sma/eq/gre hold previous values.
REQ-016 When out_valid=1, exactly one of sma/eq/gre is 1.
REQ-017 Compare mode is the signed_mode sampled with the same sample; mode may change sample to sample with no penalty.
REQ-018 Each accepted sample increments exactly one counter by 1; a counter at all-ones holds (no wrap).
REQ-019 State machine, two states: EMPTY (no sample since reset/clear) and TRACK.
REQ-020 EMPTY: stats_valid=0, a_min=a_max=0; accepted sample loads a_min=a_max=a, next state TRACK.
REQ-021 TRACK: accepted sample updates a_min if a < a_min, a_max if a > a_max, ordering per that sample's signed_mode; stats_valid=1.
REQ-022 clear=1, in_valid=0: counters -> 0, a_min/a_max -> 0, state -> EMPTY; sma/eq/gre/out_valid unaffected by clear.
REQ-023 clear=1 and in_valid=1 same edge: statistics restart with that sample -- exactly one counter = 1, others 0, a_min=a_max=a, state TRACK; out_valid/flags report the sample normally.
REQ-024 Simultaneous rst and any other input: rst wins; no sample accepted.
REQ-025 Equality in min/max update: equal value leaves register unchanged.
REQ-026 Full-width compare: no truncation; most negative and most positive codes handled correctly in both modes.

Reset
REQ-027 rst=1 at an edge: out_valid, sma, eq, gre, stats_valid = 0; all counters = 0; a_min=a_max=0; state EMPTY.
REQ-028 rst mid-stream: sample presented in a reset cycle is discarded and never counted or reported.
REQ-029 First sample accepted at the first edge with rst=0 and in_valid=1.

Verification (n=8 unless stated)
REQ-030 a=0x80, b=0x7F, signed_mode=0 -> next cycle gre=1, gt_cnt=1; same operands, signed_mode=1 -> sma=1, lt_cnt=1.
REQ-031 a=b=0x55, in_valid one cycle then low -> eq=1 with out_valid=1 one cycle, then out_valid=0 with eq still 1; eq_cnt=1.
REQ-032 CNT_W=2, five samples with a>b -> gt_cnt sequence 1,2,3,3,3.
REQ-033 Unsigned a=5, 200, 17 -> stats_valid=1 after first; final a_min=5, a_max=200; same codes signed -> a_min=0xC8 (-56), a_max=17.
REQ-034 In TRACK with counts nonzero, clear=1 and in_valid=1 with a=9, b=3 -> gt_cnt=1, lt_cnt=eq_cnt=0, a_min=a_max=9, out_valid=1, gre=1.
REQ-035 Stream running, rst=1 with in_valid=1 -> next cycle all outputs 0, state EMPTY; sample never counted.
